dmac_cfg_slave: RTL and testbench

AHB-Lite slave holding the two DMA channel descriptors (source address, destination address, transfer size, control) and a status word. It answers the configuration reads the DMAC main controller issues after a peripheral request. It also accepts descriptor writes from the CPU. It sits on the system AHB bus beside memory and implements programmable wait states and two-cycle error responses.

---
 rtl/dmac_cfg_slave.sv | 170 +++++++++++++++++
 tb/tb_dmac_cfg_slave.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_cfg_slave.sv
// dmac_cfg_slave: AHB-Lite slave holding two DMA channel descriptors
// (source, destination, size, control) plus a read-only status word.
// OKAY data phases are stretched by WAIT_STATES cycles; illegal transfers
// get a fixed two-cycle ERROR response and never touch the registers.
module dmac_cfg_slave #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSel,
    input  logic [ADDR_W-1:0] HAddr,
    input  logic [1:0]        HTrans,
    input  logic              HWrite,
    input  logic [2:0]        HSize,
    input  logic [DATA_W-1:0] HWData,
    input  logic              HReady,
    output logic              HReadyOut,
    output logic              HResp,
    output logic [DATA_W-1:0] HRData,
    output logic [1:0]        ChValid
);
    localparam logic [1:0] LP_WAIT   = 2'(WAIT_STATES);
    localparam logic [5:0] LP_STATUS = 6'h20;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_cnt;
    logic [3:0] r_idx;      // word index HAddr[5:2] of the pending data phase
    logic       r_write;
    logic [7:0] r_rdcnt;

    logic w_open;
    logic w_accept;
    logic w_illegal;
    logic w_load;
    logic w_done;
    logic w_rd_done;
    logic w_wr_done;

    logic [1:0][DATA_W-1:0] w_saddr;
    logic [1:0][DATA_W-1:0] w_daddr;
    logic [1:0][DATA_W-1:0] w_tsz;
    logic [1:0][DATA_W-1:0] w_ctrl;

    // Address bits above the 64-byte window and HTrans[0] carry no meaning here
    logic w_unused;
    assign w_unused = ^{HAddr[ADDR_W-1:6], HTrans[0]};

    // A data phase completes when DATA has run out of wait cycles
    assign w_done    = (r_state == ST_DATA) && (r_cnt == 2'd0);
    assign w_rd_done = w_done && !r_write;
    assign w_wr_done = w_done && r_write;

    // Address phases are only looked at when no data phase is being stalled
    assign w_open    = (r_state == ST_IDLE) || (r_state == ST_ERR2) || w_done;
    assign w_accept  = w_open && HSel && HReady && HTrans[1];
    assign w_illegal = (HSize != 3'b010) || (HAddr[1:0] != 2'b00) ||
                       (HAddr[5:0] > LP_STATUS) ||
                       (HWrite && (HAddr[5:0] == LP_STATUS));
    assign w_load    = w_accept && !w_illegal;

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        HReadyOut    = 1'b1;
        HResp        = 1'b0;
        case (r_state)
            ST_IDLE: ;
            ST_DATA: begin
                if (r_cnt != 2'd0) HReadyOut = 1'b0;
            end
            ST_ERR1: begin
                HReadyOut    = 1'b0;
                HResp        = 1'b1;
                w_state_next = ST_ERR2;
            end
            ST_ERR2: HResp = 1'b1;
            default: w_state_next = ST_IDLE;
        endcase
        if (w_accept)
            w_state_next = w_illegal ? ST_ERR1 : ST_DATA;
        else if (w_done || (r_state == ST_ERR2))
            w_state_next = ST_IDLE;
    end

    // State register, wait counter and latched address phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_idx   <= 4'd0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_cnt   <= LP_WAIT;
                r_idx   <= HAddr[5:2];
                r_write <= HWrite;
            end else if ((r_state == ST_DATA) && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            localparam logic LP_BANK = 1'(gi);
            logic [DATA_W-1:0] r_saddr;
            logic [DATA_W-1:0] r_daddr;
            logic [DATA_W-1:0] r_tsz;
            logic [DATA_W-1:0] r_ctrl;
            logic              w_hit;

            assign w_hit = !r_idx[3] && (r_idx[2] == LP_BANK);

            // Descriptor writes; reading Ctrl consumes the armed bit
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_saddr <= '0;
                    r_daddr <= '0;
                    r_tsz   <= '0;
                    r_ctrl  <= '0;
                end else if (w_wr_done && w_hit) begin
                    case (r_idx[1:0])
                        2'd0:    r_saddr <= HWData;
                        2'd1:    r_daddr <= HWData;
                        2'd2:    r_tsz   <= HWData;
                        default: r_ctrl  <= HWData;
                    endcase
                end else if (w_rd_done && w_hit && (r_idx[1:0] == 2'd3)) begin
                    r_ctrl[0] <= 1'b0;
                end
            end

            assign w_saddr[gi] = r_saddr;
            assign w_daddr[gi] = r_daddr;
            assign w_tsz[gi]   = r_tsz;
            assign w_ctrl[gi]  = r_ctrl;
            assign ChValid[gi] = r_ctrl[0];
        end
    endgenerate

    // Count of completed OKAY reads, wrapping at 8 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_rdcnt <= 8'd0;
        else if (w_rd_done) r_rdcnt <= r_rdcnt + 8'd1;
    end

    // Read data is driven only in the completing cycle of a read
    always_comb begin
        HRData = '0;
        if (w_rd_done) begin
            if (r_idx[3]) begin
                HRData = {ChValid, {(DATA_W-10){1'b0}}, r_rdcnt};
            end else begin
                case (r_idx[1:0])
                    2'd0:    HRData = w_saddr[r_idx[2]];
                    2'd1:    HRData = w_daddr[r_idx[2]];
                    2'd2:    HRData = w_tsz[r_idx[2]];
                    default: HRData = w_ctrl[r_idx[2]];
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dmac_cfg_slave.sv
// tb_dmac_cfg_slave: directed bench for dmac_cfg_slave. Two instances are
// used, one with WAIT_STATES=1 and one with WAIT_STATES=0; a shared master
// drives whichever is selected, and bus HReady follows that slave.
module tb_dmac_cfg_slave;
    localparam int MAXN = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsel = 1'b0;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'b010;
    logic [31:0] haddr = 32'h0;
    logic [31:0] hwdata = 32'h0;
    logic        use0 = 1'b0;

    logic        rdy1, resp1, rdy0, resp0;
    logic [31:0] rd1, rd0;
    logic [1:0]  cv1, cv0;
    logic        hready, hresp;
    logic [31:0] hrdata;
    logic [1:0]  chvalid;

    assign hready  = use0 ? rdy0  : rdy1;
    assign hresp   = use0 ? resp0 : resp1;
    assign hrdata  = use0 ? rd0   : rd1;
    assign chvalid = use0 ? cv0   : cv1;

    always #5 clk = ~clk;

    dmac_cfg_slave #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .HSel(hsel && !use0), .HAddr(haddr), .HTrans(htrans),
        .HWrite(hwrite), .HSize(hsize), .HWData(hwdata), .HReady(hready),
        .HReadyOut(rdy1), .HResp(resp1), .HRData(rd1), .ChValid(cv1)
    );

    dmac_cfg_slave #(.ADDR_W(32), .DATA_W(32), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .HSel(hsel && use0), .HAddr(haddr), .HTrans(htrans),
        .HWrite(hwrite), .HSize(hsize), .HWData(hwdata), .HReady(hready),
        .HReadyOut(rdy0), .HResp(resp0), .HRData(rd0), .ChValid(cv0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, act);
        end
    endtask

    // Transfer list and per-item results
    logic        s_wr [MAXN];
    logic [1:0]  s_tr [MAXN];
    logic [2:0]  s_sz [MAXN];
    logic [31:0] s_ad [MAXN];
    logic [31:0] s_wd [MAXN];
    logic [31:0] o_rd [MAXN];
    int          o_waits [MAXN];
    logic        o_resp_w [MAXN];
    logic        o_resp [MAXN];
    int          n_items;
    int          low_cycles;

    task automatic clear_seq();
        n_items = 0;
    endtask

    task automatic add(input logic wr, input logic [1:0] tr, input logic [2:0] sz,
                       input logic [31:0] ad, input logic [31:0] wd);
        s_wr[n_items] = wr;
        s_tr[n_items] = tr;
        s_sz[n_items] = sz;
        s_ad[n_items] = ad;
        s_wd[n_items] = wd;
        n_items++;
    endtask

    // Pipelined master: next address phase is presented while the previous
    // data phase is in progress and is taken when bus HReady is high.
    task automatic run_seq();
        int   k    = 0;
        int   pend = -1;
        int   cyc  = 0;
        logic rdy;
        for (int i = 0; i < n_items; i++) begin
            o_rd[i] = 32'h0; o_waits[i] = 0; o_resp_w[i] = 1'b0; o_resp[i] = 1'b0;
        end
        low_cycles = 0;
        @(posedge clk); #1;
        while ((k < n_items || pend >= 0) && cyc < 5000) begin
            if (k < n_items) begin
                hsel = 1'b1; htrans = s_tr[k]; hwrite = s_wr[k]; haddr = s_ad[k]; hsize = s_sz[k];
            end else begin
                hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hsize = 3'b010;
            end
            hwdata = (pend >= 0) ? s_wd[pend] : 32'h0;
            @(negedge clk);
            rdy = hready;
            if (!rdy) low_cycles++;
            if (pend >= 0) begin
                if (rdy) begin
                    o_rd[pend]   = hrdata;
                    o_resp[pend] = hresp;
                end else begin
                    if (o_waits[pend] == 0) o_resp_w[pend] = hresp;
                    o_waits[pend]++;
                end
            end
            @(posedge clk);
            if (rdy) begin
                pend = -1;
                if (k < n_items) begin
                    if (s_tr[k][1]) pend = k;
                    k++;
                end
            end
            #1;
            cyc++;
        end
        if (cyc >= 5000) check_val("seq_timeout", 32'(cyc), 32'(0));
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hwdata = 32'h0; hsize = 3'b010;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // Reset state
        @(negedge clk);
        check_val("reset_hreadyout", 32'(hready), 32'(1));
        check_val("reset_hresp", 32'(hresp), 32'(0));
        check_val("reset_hrdata", hrdata, 32'h0);
        check_val("reset_chvalid", 32'(chvalid), 32'(0));

        // WAIT_STATES=1: program bank 0 with back-to-back writes
        clear_seq();
        add(1'b1, 2'b10, 3'b010, 32'h00, 32'h1000_0000);
        add(1'b1, 2'b10, 3'b010, 32'h04, 32'h2000_0000);
        add(1'b1, 2'b10, 3'b010, 32'h08, 32'h0000_0010);
        add(1'b1, 2'b10, 3'b010, 32'h0C, 32'h0000_0001);
        run_seq();
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("wr%0d_waits", i), 32'(o_waits[i]), 32'(1));
            check_val($sformatf("wr%0d_resp", i), 32'(o_resp[i]), 32'(0));
        end
        check_val("chvalid_armed", 32'(chvalid), 32'(1));

        // Back-to-back reads of bank 0 then status
        clear_seq();
        add(1'b0, 2'b10, 3'b010, 32'h00, 32'h0);
        add(1'b0, 2'b10, 3'b010, 32'h04, 32'h0);
        add(1'b0, 2'b10, 3'b010, 32'h08, 32'h0);
        add(1'b0, 2'b10, 3'b010, 32'h0C, 32'h0);
        add(1'b0, 2'b10, 3'b010, 32'h20, 32'h0);
        run_seq();
        check_val("rd_saddr0", o_rd[0], 32'h1000_0000);
        check_val("rd_daddr0", o_rd[1], 32'h2000_0000);
        check_val("rd_tsz0", o_rd[2], 32'h0000_0010);
        check_val("rd_ctrl0", o_rd[3], 32'h0000_0001);
        check_val("rd_status", o_rd[4], 32'h0000_0004);
        for (int i = 0; i < 5; i++)
            check_val($sformatf("rd%0d_waits", i), 32'(o_waits[i]), 32'(1));
        check_val("chvalid_consumed", 32'(chvalid), 32'(0));

        // WAIT_STATES=0: reads of bank 1 with a Busy (write-flavoured) between
        use0 = 1'b1;
        clear_seq();
        add(1'b1, 2'b10, 3'b010, 32'h10, 32'hAAAA_0001);
        add(1'b1, 2'b10, 3'b010, 32'h14, 32'hBBBB_0002);
        run_seq();
        clear_seq();
        add(1'b0, 2'b10, 3'b010, 32'h10, 32'h0);
        add(1'b1, 2'b01, 3'b010, 32'h10, 32'h0);
        add(1'b0, 2'b10, 3'b010, 32'h14, 32'h5555_5555);
        add(1'b0, 2'b10, 3'b010, 32'h20, 32'h0);
        add(1'b0, 2'b10, 3'b010, 32'h10, 32'h0);
        run_seq();
        check_val("ws0_low_cycles", 32'(low_cycles), 32'(0));
        check_val("ws0_rd_saddr1", o_rd[0], 32'hAAAA_0001);
        check_val("ws0_rd_daddr1", o_rd[2], 32'hBBBB_0002);
        check_val("ws0_status", o_rd[3], 32'h0000_0002);
        check_val("ws0_saddr1_after_busy", o_rd[4], 32'hAAAA_0001);
        use0 = 1'b0;

        // Error responses on the WAIT_STATES=1 slave
        clear_seq();
        add(1'b0, 2'b10, 3'b010, 32'h24, 32'h0);
        add(1'b1, 2'b10, 3'b010, 32'h20, 32'hFFFF_FFFF);
        add(1'b1, 2'b10, 3'b000, 32'h00, 32'hFFFF_FFFF);
        add(1'b0, 2'b10, 3'b010, 32'h00, 32'h0);
        add(1'b0, 2'b10, 3'b010, 32'h20, 32'h0);
        run_seq();
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("err%0d_err1_cycles", i), 32'(o_waits[i]), 32'(1));
            check_val($sformatf("err%0d_err1_resp", i), 32'(o_resp_w[i]), 32'(1));
            check_val($sformatf("err%0d_err2_resp", i), 32'(o_resp[i]), 32'(1));
        end
        check_val("err_saddr0_kept", o_rd[3], 32'h1000_0000);
        check_val("err_status", o_rd[4], 32'h0000_0006);

        // RdCnt wrap after 256 OKAY reads
        do_reset();
        clear_seq();
        add(1'b1, 2'b10, 3'b010, 32'h10, 32'h1234_5678);
        run_seq();
        clear_seq();
        for (int i = 0; i < 256; i++) add(1'b0, 2'b10, 3'b010, 32'h10, 32'h0);
        add(1'b0, 2'b10, 3'b010, 32'h20, 32'h0);
        run_seq();
        for (int i = 0; i < 256; i++)
            if (o_rd[i] !== 32'h1234_5678) check_val($sformatf("wrap_rd%0d", i), o_rd[i], 32'h1234_5678);
        check_val("wrap_rd_last", o_rd[255], 32'h1234_5678);
        check_val("wrap_status", o_rd[256], 32'h0000_0000);

        // Ctrl re-arm and consume only bit 0
        clear_seq();
        add(1'b1, 2'b10, 3'b010, 32'h0C, 32'h0000_0001);
        add(1'b1, 2'b10, 3'b010, 32'h1C, 32'h0000_0003);
        run_seq();
        check_val("chvalid_both", 32'(chvalid), 32'(3));
        clear_seq();
        add(1'b0, 2'b10, 3'b010, 32'h1C, 32'h0);
        add(1'b0, 2'b10, 3'b010, 32'h1C, 32'h0);
        run_seq();
        check_val("rd_ctrl1_first", o_rd[0], 32'h0000_0003);
        check_val("rd_ctrl1_second", o_rd[1], 32'h0000_0002);
        check_val("chvalid_bank0_only", 32'(chvalid), 32'(1));

        // Reset during the wait state of a write to DAddr1
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h14; hsize = 3'b010;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 32'h0; hwdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_val("midrst_wait_state", 32'(hready), 32'(0));
        rst = 1'b1;
        #1;
        check_val("midrst_hreadyout", 32'(hready), 32'(1));
        check_val("midrst_hresp", 32'(hresp), 32'(0));
        check_val("midrst_chvalid", 32'(chvalid), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0; hwdata = 32'h0;
        clear_seq();
        add(1'b0, 2'b10, 3'b010, 32'h14, 32'h0);
        add(1'b0, 2'b10, 3'b010, 32'h20, 32'h0);
        run_seq();
        check_val("midrst_daddr1", o_rd[0], 32'h0000_0000);
        check_val("midrst_status", o_rd[1], 32'h0000_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
